// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: checkpoint geometry, branch-id layout and
// the checkpoint controller FSM encoding.
package decode_pkg;

  localparam int CP_NUM   = 4;
  localparam int CP_IDX_W = 2;
  localparam int BID_W    = 4;

  typedef logic [CP_IDX_W-1:0] cp_idx_t;

  // Branch id as handed to decode: upper bits count how many times the slot
  // has been reused, lower bits name the slot.
  typedef struct packed {
    logic [1:0] lap;
    cp_idx_t    slot;
  } bid_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_SNOOP   = 2'd2
  } cp_state_e;

  // Build a branch id from a lap count and a slot index.
  function automatic bid_t make_bid(input logic [1:0] lap, input cp_idx_t slot);
    bid_t b;
    b.lap  = lap;
    b.slot = slot;
    return b;
  endfunction

endpackage

// File: rtl/decode_rat_cp_ring.sv
// Ring bookkeeping for the checkpoint slots: head/tail pointers, occupancy
// count, per-slot lap counters and the busy vector. The caller guarantees the
// controls are legal (no alloc when full, no retire when empty).
module decode_rat_cp_ring
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_alloc,
  input  logic              i_retire,
  input  logic              i_recover,
  input  logic              i_flush,
  output cp_idx_t           o_head,
  output cp_idx_t           o_tail,
  output logic [2:0]        o_count,
  output logic [CP_NUM-1:0] o_busy,
  output bid_t              o_head_bid,
  output bid_t              o_tail_bid
);

  cp_idx_t           r_head;
  cp_idx_t           r_tail;
  logic [2:0]        r_count;
  logic [CP_NUM-1:0] r_busy;
  logic [1:0]        r_lap [CP_NUM];

  logic [CP_NUM-1:0] w_set_mask;
  logic [CP_NUM-1:0] w_clr_mask;

  // One-hot masks for the slot being allocated and the slot being retired.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_alloc)  w_set_mask[r_tail] = 1'b1;
    if (i_retire) w_clr_mask[r_head] = 1'b1;
  end

  // Ring state update; flush beats recover beats the normal alloc/retire pair.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      r_lap   <= '{default: '0};
    end else if (i_flush) begin
      r_busy  <= '0;
      r_count <= '0;
      r_tail  <= r_head;
    end else if (i_recover) begin
      // The mispredicted branch's slot is consumed; everything younger is gone.
      r_lap[r_head] <= r_lap[r_head] + 2'd1;
      r_busy        <= '0;
      r_count       <= '0;
      r_head        <= r_head + 2'd1;
      r_tail        <= r_head + 2'd1;
    end else begin
      if (i_alloc) r_tail <= r_tail + 2'd1;
      if (i_retire) begin
        r_head        <= r_head + 2'd1;
        r_lap[r_head] <= r_lap[r_head] + 2'd1;
      end
      r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
      case ({i_alloc, i_retire})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head     = r_head;
  assign o_tail     = r_tail;
  assign o_count    = r_count;
  assign o_busy     = r_busy;
  assign o_head_bid = make_bid(r_lap[r_head], r_head);
  assign o_tail_bid = make_bid(r_lap[r_tail], r_tail);

endmodule

// File: rtl/decode_rat_checkpoint_ctrl.sv
// Allocation / retirement / recovery controller for the RAT checkpoint array.
// Drives every write and invalidate strobe into the array combinationally and
// keeps a shadow occupancy vector that is cross-checked against the array.
module decode_rat_checkpoint_ctrl
  import decode_pkg::*;
#(
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snoop_hit,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [BID_W-1:0] alloc_bid,
  input  logic             commit_valid,
  input  logic [BID_W-1:0] commit_bid,
  input  logic             commit_mispredict,
  output logic             rat_restore,
  output logic             cp_wea,
  output logic [1:0]       cp_addra,
  output logic             cp_web,
  output logic [1:0]       cp_addrb,
  output logic             cp_wef,
  output logic [BID_W-1:0] cp_dinf_bid,
  input  logic [CP_NUM-1:0] cp_valid,
  output logic [CP_NUM-1:0] busy,
  output logic             err
);

  localparam logic [3:0] RC_LOAD = 4'(RECOVER_CYCLES - 1);

  cp_state_e r_state;
  cp_state_e w_state_nxt;
  logic [3:0] r_rcnt;
  logic       r_first;
  logic       r_err;

  cp_idx_t           w_head;
  cp_idx_t           w_tail;
  logic [2:0]        w_count;
  logic [CP_NUM-1:0] w_busy;
  bid_t              w_head_bid;
  bid_t              w_tail_bid;

  logic w_ok;
  logic w_run;
  logic w_nonempty;
  logic w_head_match;
  logic w_mis;
  logic w_mis_do;
  logic w_ret_do;
  logic w_grant;
  logic w_err_set;

  decode_rat_cp_ring u_ring (
    .clk        (clk),
    .i_rst      (reset),
    .i_alloc    (w_grant),
    .i_retire   (w_ret_do),
    .i_recover  (w_mis_do),
    .i_flush    (snoop_hit),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_count    (w_count),
    .o_busy     (w_busy),
    .o_head_bid (w_head_bid),
    .o_tail_bid (w_tail_bid)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state: a snoop hit overrides everything, recovery only starts from RUN.
  always_comb begin
    w_state_nxt = r_state;
    if (snoop_hit) begin
      w_state_nxt = ST_SNOOP;
    end else begin
      case (r_state)
        ST_RUN:     if (w_mis_do) w_state_nxt = ST_RECOVER;
        ST_RECOVER: if (r_rcnt == 4'd0) w_state_nxt = ST_RUN;
        ST_SNOOP:   w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Outputs and event decode; reset and snoop suppress every array strobe.
  always_comb begin
    w_ok         = ~reset & ~snoop_hit;
    w_run        = (r_state == ST_RUN);
    w_nonempty   = (w_count != 3'd0);
    w_head_match = (commit_bid == w_head_bid);
    w_mis        = commit_valid & commit_mispredict;
    w_mis_do     = w_ok & w_run & w_mis & w_nonempty;
    w_ret_do     = w_ok & w_run & commit_valid & ~commit_mispredict
                 & w_nonempty & w_head_match;
    // A slot freed this cycle is not offered again until the next one, since
    // the array resolves a same-line wef/wea collision in favour of wef.
    alloc_ready  = w_ok & w_run & (w_count < 3'd4) & ~w_mis;
    w_grant      = alloc_req & alloc_ready;

    cp_wea       = w_grant;
    cp_addra     = w_tail;
    alloc_bid    = w_tail_bid;
    cp_web       = w_mis_do;
    cp_addrb     = w_head;
    rat_restore  = w_mis_do;
    cp_wef       = w_mis_do | w_ret_do;
    cp_dinf_bid  = commit_bid;

    w_err_set = 1'b0;
    if (w_ok & commit_valid) begin
      if (!w_run)             w_err_set = 1'b1;
      else if (!w_nonempty)   w_err_set = 1'b1;
      else if (!w_head_match) w_err_set = 1'b1;
    end
    // The array lags a state change by a cycle, so skip the compare right
    // after any transition.
    if (~reset & w_run & ~r_first & (cp_valid != w_busy)) w_err_set = 1'b1;
  end

  // Recovery hold-off counter, loaded on entry to RECOVER.
  always_ff @(posedge clk) begin
    if (reset)
      r_rcnt <= '0;
    else if (w_run && w_state_nxt == ST_RECOVER)
      r_rcnt <= RC_LOAD;
    else if (r_state == ST_RECOVER && r_rcnt != 4'd0)
      r_rcnt <= r_rcnt - 4'd1;
  end

  // Marks the first cycle after reset or any state transition.
  always_ff @(posedge clk) begin
    if (reset) r_first <= 1'b1;
    else       r_first <= (w_state_nxt != r_state);
  end

  // Sticky protocol/consistency error.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err | w_err_set;
  end

  assign busy = w_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_decode_rat_checkpoint_ctrl.sv
// Bench for decode_rat_checkpoint_ctrl: directed scenarios followed by random
// traffic, all checked against a queue-based model of outstanding branches.
module tb_decode_rat_checkpoint_ctrl;
  import decode_pkg::*;

  localparam int RC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, snoop_hit = 1'b0, alloc_req = 1'b0;
  logic       commit_valid = 1'b0, commit_mispredict = 1'b0;
  logic [3:0] commit_bid = '0, cp_valid = '0;
  logic       alloc_ready, rat_restore, cp_wea, cp_web, cp_wef, err;
  logic [3:0] alloc_bid, cp_dinf_bid, busy;
  logic [1:0] cp_addra, cp_addrb;

  always #5 clk = ~clk;

  decode_rat_checkpoint_ctrl #(.RECOVER_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .snoop_hit(snoop_hit),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_bid(alloc_bid),
    .commit_valid(commit_valid), .commit_bid(commit_bid),
    .commit_mispredict(commit_mispredict), .rat_restore(rat_restore),
    .cp_wea(cp_wea), .cp_addra(cp_addra), .cp_web(cp_web), .cp_addrb(cp_addrb),
    .cp_wef(cp_wef), .cp_dinf_bid(cp_dinf_bid), .cp_valid(cp_valid),
    .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: outstanding branch ids in program order.
  int q[$];
  int m_head, m_mode, m_rem;  // mode 0 = run, 1 = recover, 2 = snoop
  int m_lap[4];
  bit m_err, m_first, m_primed;

  function automatic logic [3:0] m_busy();
    logic [3:0] b = '0;
    foreach (q[i]) b[q[i] % 4] = 1'b1;
    return b;
  endfunction

  // Drive one cycle's inputs at the falling edge and compare combinational
  // outputs plus registered state against the model.
  task automatic drive(input bit rs, input bit sn, input bit rq, input bit cv,
                       input bit mi, input logic [3:0] bid, input bit corrupt);
    int sz, tl;
    bit ok, run, e_ready, e_web, e_wef;
    @(negedge clk);
    reset = rs; snoop_hit = sn; alloc_req = rq;
    commit_valid = cv; commit_mispredict = mi; commit_bid = bid;
    cp_valid = m_busy() ^ (corrupt ? 4'h1 : 4'h0);
    #1;
    sz = q.size(); tl = (m_head + sz) % 4;
    ok = !rs && !sn; run = (m_mode == 0);
    e_ready = ok && run && sz < 4 && !(cv && mi);
    e_web   = ok && run && cv && mi && sz > 0;
    e_wef   = e_web || (ok && run && cv && !mi && sz > 0 && int'(bid) == q[0]);
    check_eq("alloc_ready", alloc_ready, e_ready);
    check_eq("cp_wea", cp_wea, e_ready && rq);
    if (e_ready && rq) check_eq("cp_addra", cp_addra, tl);
    if (!rs) check_eq("alloc_bid", alloc_bid, m_lap[tl] * 4 + tl);
    check_eq("cp_web", cp_web, e_web);
    check_eq("rat_restore", rat_restore, e_web);
    if (e_web) check_eq("cp_addrb", cp_addrb, m_head);
    check_eq("cp_wef", cp_wef, e_wef);
    if (e_wef) check_eq("cp_dinf_bid", cp_dinf_bid, bid);
    if (m_primed) begin
      check_eq("busy", busy, m_busy());
      check_eq("err", err, m_err);
    end
  endtask

  // Apply the rising edge to the model using the inputs the DUT sampled.
  task automatic advance();
    int sz, tl, tl_lap, old;
    bit grant;
    @(posedge clk);
    if (reset) begin
      q.delete(); m_head = 0; m_mode = 0; m_rem = 0;
      foreach (m_lap[i]) m_lap[i] = 0;
      m_err = 0; m_first = 1; m_primed = 1;
      return;
    end
    old = m_mode; sz = q.size(); tl = (m_head + sz) % 4; tl_lap = m_lap[tl];
    if (m_mode == 0 && !m_first && cp_valid != m_busy()) m_err = 1;
    if (snoop_hit) begin
      q.delete(); m_mode = 2;
    end else begin
      case (m_mode)
        0: begin
          if (commit_valid && commit_mispredict) begin
            if (sz == 0) m_err = 1;
            else begin
              if (int'(commit_bid) != q[0]) m_err = 1;
              m_lap[m_head] = (m_lap[m_head] + 1) % 4;
              m_head = (m_head + 1) % 4;
              q.delete(); m_mode = 1; m_rem = RC - 1;
            end
          end else begin
            grant = alloc_req && sz < 4;
            if (commit_valid) begin
              if (sz > 0 && int'(commit_bid) == q[0]) begin
                void'(q.pop_front());
                m_lap[m_head] = (m_lap[m_head] + 1) % 4;
                m_head = (m_head + 1) % 4;
              end else m_err = 1;
            end
            if (grant) q.push_back(tl_lap * 4 + tl);
          end
        end
        1: begin
          if (commit_valid) m_err = 1;
          if (m_rem == 0) m_mode = 0; else m_rem--;
        end
        default: begin
          if (commit_valid) m_err = 1;
          m_mode = 0;
        end
      endcase
    end
    m_first = (m_mode != old);
  endtask

  task automatic cyc(input bit rs, input bit sn, input bit rq, input bit cv,
                     input bit mi, input logic [3:0] bid);
    drive(rs, sn, rq, cv, mi, bid, 1'b0);
    advance();
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 0, 0);
  endtask

  int snoop_left = 0;

  initial begin
    m_primed = 0;

    // Four grants from reset fill the ring.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      check_eq("tp1_bid", alloc_bid, k);
      check_eq("tp1_addra", cp_addra, k);
      advance();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    check_eq("tp1_busy", busy, 4'hF);
    check_eq("tp1_full_ready", alloc_ready, 0);
    advance();

    // Commit the oldest of a full ring, then the freed slot comes back at lap 1.
    drive(0, 0, 0, 1, 0, 4'h0, 0);
    check_eq("tp2_wef", cp_wef, 1);
    check_eq("tp2_dinf", cp_dinf_bid, 4'h0);
    advance();
    drive(0, 0, 1, 0, 0, 0, 0);
    check_eq("tp2_ready", alloc_ready, 1);
    check_eq("tp2_bid", alloc_bid, 4'h4);
    advance();

    // Mispredict on slot 0 with three branches in flight.
    do_reset();
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 1, 4'h0, 0);
    check_eq("tp3_web", cp_web, 1);
    check_eq("tp3_addrb", cp_addrb, 0);
    check_eq("tp3_restore", rat_restore, 1);
    check_eq("tp3_wea", cp_wea, 0);
    advance();
    for (int k = 0; k < RC; k++) begin
      drive(0, 0, 1, 0, 0, 0, 0);
      check_eq("tp3_busy", busy, 0);
      check_eq("tp3_hold", alloc_ready, 0);
      advance();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    check_eq("tp3_bid", alloc_bid, 4'h1);
    check_eq("tp3_ready", alloc_ready, 1);
    advance();

    // Out-of-order commit is refused and the error sticks until reset.
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 4'h1, 0);
    check_eq("tp4_wef", cp_wef, 0);
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check_eq("tp4_err", err, 1);
      advance();
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_eq("tp4_err_clr", err, 0);
    advance();

    // Snoop for three cycles while recovering.
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 4'h0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      check_eq("tp5_ready", alloc_ready, 0);
      advance();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    check_eq("tp5_tail_ready", alloc_ready, 0);
    check_eq("tp5_busy", busy, 0);
    advance();
    drive(0, 0, 1, 0, 0, 0, 0);
    check_eq("tp5_ready_back", alloc_ready, 1);
    check_eq("tp5_err", err, 0);
    advance();

    // Reset mid-RECOVER with a request pending.
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 4'h0);
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 1, 1, 0, 4'h0, 0);
      check_eq("tp6_wea", cp_wea, 0);
      check_eq("tp6_wef", cp_wef, 0);
      advance();
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    check_eq("tp6_busy", busy, 0);
    check_eq("tp6_err", err, 0);
    check_eq("tp6_bid", alloc_bid, 4'h0);
    check_eq("tp6_wea_after", cp_wea, 1);
    advance();

    // Array valid disagreeing with the shadow vector raises err.
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_eq("cons_err", err, 1);
    advance();

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit rs, sn, rq, cv, mi, cor;
      logic [3:0] bid;
      rs = ($urandom % 80) == 0;
      if (snoop_left == 0 && ($urandom % 40) == 0) snoop_left = 1 + $urandom % 3;
      sn = snoop_left > 0;
      if (snoop_left > 0) snoop_left--;
      rq  = ($urandom % 10) < 7;
      cv  = ($urandom % 10) < 4;
      mi  = ($urandom % 10) == 0;
      bid = (q.size() > 0 && ($urandom % 10) != 0) ? 4'(q[0]) : 4'($urandom % 16);
      cor = ($urandom % 400) == 0;
      drive(rs, sn, rq, cv, mi, bid, cor);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_rat_checkpoint_ctrl.md
# decode_rat_checkpoint_ctrl

Allocation and recovery controller for the 4-entry RAT checkpoint array in decode. It hands out checkpoint slots to decoded branches in program order. It retires slots as branches commit, and sequences the recovery read plus set invalidation when a branch mispredicts. On a snoop hit it empties the array and stalls allocation. It owns every write/invalidate strobe into the checkpoint array, and keeps a shadow occupancy model that it cross-checks against the array's `valid` output.

## Interface
- `RECOVER_CYCLES`, default 2: cycles allocation stays blocked after a mispredict recovery (range 1..15).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `snoop_hit`  in  1  snoop flush; also wired directly to the array.
- `alloc_req`  in  1  decode holds a branch that needs a checkpoint.
- `alloc_ready`  out  1  a slot can be granted this cycle.
- `alloc_bid`  out  4  branch id granted: `[1:0]` slot, `[3:2]` lap count.
- `commit_valid`  in  1  the oldest branch commits.
- `commit_bid`  in  4  id of the committing branch.
- `commit_mispredict`  in  1  the committing branch mispredicted.
- `rat_restore`  out  1  the RAT must load `doutb_*` from the array this cycle.
- `cp_wea` / `cp_addra`  out  1/2  array snapshot write.
- `cp_web` / `cp_addrb`  out  1/2  array recovery read and set invalidation.
- `cp_wef` / `cp_dinf_bid`  out  1/4  array line invalidation.
- `cp_valid`  in  4  array `valid` output.
- `busy`  out  4  shadow occupancy vector.
- `err`  out  1  sticky protocol/consistency error.

## Operation
- The controller keeps a ring of 4 slots: `head[1:0]` (oldest), `tail[1:0]` (next to allocate), `count[2:0]` (0..4) and `lap[1:0]` per slot.
- `busy[s]` = slot `s` is allocated and not yet committed.
- FSM states: RUN, RECOVER, SNOOP. Reset state is RUN, with head = tail = count = 0, all laps 0, `err` = 0.
- `alloc_ready` = RUN & `count` < 4 & ~`commit_mispredict`-qualified commit & ~`snoop_hit`. The count used is the registered value; a slot freed by a same-cycle commit is not reusable until the next cycle, because the array gives `wef` priority over `wea`.
- Grant = `alloc_req` & `alloc_ready`. On a grant:
  - `cp_wea` = 1, `cp_addra` = `tail`, `alloc_bid` = {`lap[tail]`, `tail`}, all combinational.
  - Next cycle: `tail`+1, `count`+1, `busy[tail]` set.
- Normal commit (`commit_valid` & ~`commit_mispredict`):
  - If `count` > 0 and `commit_bid` == {`lap[head]`, `head`}: `cp_wef` = 1, `cp_dinf_bid` = `commit_bid`; next cycle `head`+1, `count`-1, `busy[head]` cleared, `lap[head]`+1.
  - Otherwise: no strobe, and `err` is set.
- Mispredict commit (`commit_valid` & `commit_mispredict`, bid must match head):
  - Same cycle: `cp_web` = 1, `cp_addrb` = `head`, `rat_restore` = 1, and `cp_wef` = 1 with `cp_dinf_bid` = `commit_bid`.
  - Next cycle: `lap[head]`+1, `busy` = 0, `count` = 0, `tail` = `head`+1, `head` = `head`+1; enter RECOVER.
  - A bid mismatch sets `err` but still performs the recovery.
- RECOVER: a down-counter is loaded with `RECOVER_CYCLES`-1; `alloc_ready` = 0. The FSM returns to RUN after the counter reaches 0. Commits arriving in RECOVER set `err`, since the ring is empty.
- SNOOP: entered from any state when `snoop_hit` = 1.
  - Each `snoop_hit` cycle: `busy` = 0, `count` = 0, `tail` = `head`; pending RECOVER is abandoned.
  - The FSM stays in SNOOP while `snoop_hit` = 1, then spends exactly one further cycle in SNOOP after it drops, then goes to RUN.
  - No `cp_*` strobes are driven in SNOOP.
- Simultaneous events, priority: `reset` > `snoop_hit` > mispredict commit > normal commit / grant.
  - A normal commit and a grant in the same cycle both take effect, and `count` is unchanged.
  - A mispredict suppresses the same-cycle grant.
- Consistency check: in RUN, outside the first cycle after any state transition, `cp_valid` != `busy` sets `err`.

## Timing
- Every `cp_*` strobe, `alloc_bid` and `rat_restore` is combinational from registered state and same-cycle inputs; zero-cycle latency into the array.
- Registered state updates one cycle after the causing event.
- Reset (held any number of cycles, including mid-RECOVER or mid-SNOOP):
  - While asserted: `alloc_ready` = 0, all `cp_*` strobes = 0, `rat_restore` = 0.
  - In the cycle after deassertion: `busy` = 0, `err` = 0, `alloc_bid` = 0.
- Full ring (`count` = 4): `alloc_ready` = 0 until the cycle after a commit.
- Pointer and lap arithmetic wraps modulo 4; `count` never exceeds 4 or drops below 0. A commit on empty sets `err` and changes no state.

## Structure
- Shared package `decode_pkg`, holding:
  - `CP_NUM` = 4, `CP_IDX_W` = 2, `BID_W` = 4;
  - a typedef for bid as {lap, slot};
  - the FSM state enum (RUN, RECOVER, SNOOP).
- One natural sub-module: `decode_rat_cp_ring`, holding the head/tail/count/lap/busy bookkeeping with increment/clear controls. The FSM, priority logic and checks stay in the top.

## Test plan
- Reset, then 4 grants with no commits → `alloc_bid` = 0x0, 0x1, 0x2, 0x3; `busy` = 0xF; `alloc_ready` = 0; `cp_addra` follows 0..3.
- Full ring, then commit bid 0x0 → `cp_wef` = 1, `cp_dinf_bid` = 0x0; next cycle `alloc_ready` = 1; next grant gives bid 0x4 (lap 1, slot 0).
- Slots 0..2 allocated, then mispredict commit bid 0x0 → same cycle `cp_web` = 1, `cp_addrb` = 0, `rat_restore` = 1; then `busy` = 0; `alloc_ready` = 0 for 2 cycles; next grant gives bid 0x1.
- Commit bid 0x1 while head is slot 0 → no `cp_wef`; `err` = 1 and stays 1 until reset.
- `snoop_hit` for 3 cycles during RECOVER → `busy` = 0; `alloc_ready` = 0 for those 3 cycles plus 1; `err` stays 0.
- Reset asserted mid-RECOVER with a grant request pending → no strobes; after release, `busy` = 0, `err` = 0, and `alloc_bid` = 0x0 when `alloc_req` is asserted.
